inter_rr: RTL and testbench

- Parametrised N-master to M-slave write interconnect.
- Each master posts a one-cycle write word {slave_sel, addr, value} into a 1-deep per-master holding register.
- A round-robin arbiter picks one pending master at a time and drives the selected slave over a valid/ready handshake, with a registered completion pulse.
- Sits between producer blocks and register-bank slaves; it is the multi-channel successor of the 2x2 fixed-order interconnect.

---
 rtl/inter_rr_pkg.sv | 16 +
 rtl/inter_rr_arb.sv | 32 +++
 rtl/inter_rr.sv | 179 +++++++++++++++++
 tb/tb_inter_rr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inter_rr_pkg.sv
// Shared types and default sizing for the inter_rr N-master to M-slave write interconnect.
package inter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HS   = 2'd2
  } state_e;

  localparam int DEF_N_MST   = 2;
  localparam int DEF_N_SLV   = 2;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_VAL_W   = 3;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/inter_rr_arb.sv
// Combinational N-way round-robin arbiter: first request at or after ptr_i, scanning upward with wrap.
module inter_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // NOTE: every output gets a default before the scan so no path leaves a value unassigned (no latch).
  always_comb begin
    logic found;
    int   j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/inter_rr.sv
// Round-robin N-master to M-slave write interconnect with 1-deep per-master holding registers.
// Optional stall abort enabled by defining INTER_TIMEOUT_EN.
module inter_rr
  import inter_pkg::*;
#(
  parameter int N_MST   = DEF_N_MST,
  parameter int N_SLV   = DEF_N_SLV,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int VAL_W   = DEF_VAL_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int SEL_W  = $clog2(N_SLV),
  localparam int DATA_W = SEL_W + ADDR_W + VAL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MST-1:0]        in_valid,
  input  logic [N_MST*DATA_W-1:0] data_in,
  output logic [N_MST-1:0]        in_ready,
  input  logic [N_SLV-1:0]        ready_slave,
  output logic [N_SLV-1:0]        valid_slave,
  output logic [ADDR_W-1:0]       addr_out,
  output logic [VAL_W-1:0]        value_out,
  output logic [N_SLV-1:0]        handshake_slave,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(N_MST);

  if (N_MST < 2 || N_MST > 8 || N_SLV < 2 || N_SLV > 8 ||
      (N_SLV & (N_SLV - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("inter_rr: unsupported parameter set");
  end

  state_e              state_q, state_d;
  logic [N_MST-1:0]    pending_q, pending_d, cap, clr;
  logic [DATA_W-1:0]   word_q [N_MST];
  logic [DATA_W-1:0]   word_sel;
  logic [IDX_W-1:0]    ptr_q, ptr_d, gnt_q, gnt_d, ptr_nxt;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_SLV-1:0]    valid_q, valid_d, hs_q, hs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [VAL_W-1:0]    value_q, value_d;
  logic [N_MST-1:0]    arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  inter_rr_arb #(.N(N_MST), .IDX_W(IDX_W)) u_arb (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N_MST; i++) word_sel = word_sel | ({DATA_W{arb_gnt[i]}} & word_q[i]);
  end

  // A strobe into a full holding register is dropped, even on the edge that empties it.
  assign cap       = in_valid & ~pending_q;
  assign pending_d = (pending_q & ~clr) | cap;
  assign ptr_nxt   = (gnt_q == IDX_W'(N_MST - 1)) ? '0 : gnt_q + 1'b1;

`ifdef INTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    value_d = value_q;
    hs_d    = '0;
    clr     = '0;
`ifdef INTER_TIMEOUT_EN
    cnt_d   = '0;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE, HS: begin
        valid_d = '0;
        addr_d  = '0;
        value_d = '0;
        if (arb_any) begin
          state_d = SEND;
          gnt_d   = arb_idx;
          sel_d   = word_sel[DATA_W-1 -: SEL_W];
          valid_d[word_sel[DATA_W-1 -: SEL_W]] = 1'b1;
          addr_d  = word_sel[VAL_W +: ADDR_W];
          value_d = word_sel[VAL_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (ready_slave[sel_q]) begin
          state_d    = HS;
          hs_d       = valid_q;
          valid_d    = '0;
          addr_d     = '0;
          value_d    = '0;
          clr[gnt_q] = 1'b1;
          ptr_d      = ptr_nxt;
        end
`ifdef INTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          to_d       = 1'b1;
          valid_d    = '0;
          addr_d     = '0;
          value_d    = '0;
          clr[gnt_q] = 1'b1;
          ptr_d      = ptr_nxt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= '0;
      addr_q    <= '0;
      value_q   <= '0;
      hs_q      <= '0;
      // NOTE: the holding words are a few flops, not RAM, so they take the defined all-zero reset.
      for (int i = 0; i < N_MST; i++) word_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      hs_q      <= hs_d;
      for (int i = 0; i < N_MST; i++)
        if (cap[i]) word_q[i] <= data_in[i*DATA_W +: DATA_W];
    end
  end

`ifdef INTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign timeout_err = to_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready        = ~pending_q;
  assign valid_slave     = valid_q;
  assign addr_out        = addr_q;
  assign value_out       = value_q;
  assign handshake_slave = hs_q;

endmodule

// File: tb/tb_inter_rr.sv
// Self-checking bench for inter_rr: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model. Honours INTER_TIMEOUT_EN.
module tb_inter_rr;

  localparam int N  = 2;
  localparam int S  = 2;
  localparam int AW = 3;
  localparam int VW = 3;
  localparam int DW = 7;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  in_ready;
  logic [S-1:0]  ready_slave;
  logic [S-1:0]  valid_slave;
  logic [AW-1:0] addr_out;
  logic [VW-1:0] value_out;
  logic [S-1:0]  handshake_slave;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  inter_rr #(.N_MST(N), .N_SLV(S), .ADDR_W(AW), .VAL_W(VW), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .data_in         (data_in),
    .in_ready        (in_ready),
    .ready_slave     (ready_slave),
    .valid_slave     (valid_slave),
    .addr_out        (addr_out),
    .value_out       (value_out),
    .handshake_slave (handshake_slave),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: pending flags and words per master, the master currently being
  // sent (-1 when none), the rr pointer and a stall counter.
  bit mpend [N];
  int mword [N];
  int mptr, mcur, mcnt, m_hs, m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin mpend[i] = 1'b0; mword[i] = 0; end
      mptr = 0; mcur = -1; mcnt = 0; m_hs = 0; m_to = 0;
    end else begin : step
      bit old [N];
      int s;
      old  = mpend;
      m_hs = 0;
      m_to = 0;
      if (mcur >= 0) begin
        s = mword[mcur] >> (AW + VW);
        if (ready_slave[s]) begin
          m_hs = 1 << s;
          mpend[mcur] = 1'b0;
          mptr = (mcur + 1) % N;
          mcur = -1;
        end
`ifdef INTER_TIMEOUT_EN
        else begin
          mcnt++;
          if (mcnt == TIMEOUT) begin
            m_to = 1;
            mpend[mcur] = 1'b0;
            mptr = (mcur + 1) % N;
            mcur = -1;
          end
        end
`endif
      end else begin
        for (int k = 0; k < N; k++) begin
          if (mcur < 0 && old[(mptr + k) % N]) begin
            mcur = (mptr + k) % N;
            mcnt = 0;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && !old[i]) begin
          mpend[i] = 1'b1;
          mword[i] = int'(data_in[i*DW +: DW]);
        end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin : cmp
      int ev, ea, evl, ir;
      ev = 0; ea = 0; evl = 0; ir = 0;
      if (mcur >= 0) begin
        ev  = 1 << (mword[mcur] >> (AW + VW));
        ea  = (mword[mcur] >> VW) % (1 << AW);
        evl = mword[mcur] % (1 << VW);
      end
      for (int i = 0; i < N; i++) if (!mpend[i]) ir = ir | (1 << i);
      check("model valid_slave", 32'(valid_slave), ev);
      check("model addr_out", 32'(addr_out), ea);
      check("model value_out", 32'(value_out), evl);
      check("model handshake_slave", 32'(handshake_slave), m_hs);
      check("model in_ready", 32'(in_ready), ir);
      check("model timeout_err", 32'(timeout_err), m_to);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic post(input logic [N-1:0] v, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    in_valid = v;
    data_in  = {w1, w0};
    tick();
    in_valid = '0;
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; in_valid = '0; data_in = '0; ready_slave = '0;
    tick(2);
    check("reset in_ready", 32'(in_ready), 32'h3);
    check("reset valid_slave", 32'(valid_slave), 32'h0);
    check("reset handshake", 32'(handshake_slave), 32'h0);
    check("reset timeout_err", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;

    // Single write to slave 0
    ready_slave = 2'b01;
    post(2'b01, 7'b0_101_011, '0);
    check("single in_ready", 32'(in_ready), 32'h2);
    tick();
    check("single valid", 32'(valid_slave), 32'h1);
    check("single addr", 32'(addr_out), 32'd5);
    check("single value", 32'(value_out), 32'd3);
    tick();
    check("single hs", 32'(handshake_slave), 32'h1);
    check("single valid off", 32'(valid_slave), 32'h0);
    tick();
    check("single hs off", 32'(handshake_slave), 32'h0);

    // Routing to slave 1 with a 5-cycle stall
    ready_slave = 2'b00;
    post(2'b10, '0, 7'b1_010_110);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("route valid held", 32'(valid_slave), 32'h2);
      check("route addr held", 32'(addr_out), 32'd2);
      check("route value held", 32'(value_out), 32'd6);
      check("route in_ready1", 32'(in_ready[1]), 32'h0);
    end
    ready_slave = 2'b10;
    tick();
    check("route hs", 32'(handshake_slave), 32'h2);
    tick();

    // Fairness: both masters strobe together, four rounds
    ready_slave = 2'b11;
    for (int rnd = 0; rnd < 4; rnd++) begin
      post(2'b11, 7'b0_000_001, 7'b1_000_010);
      tick();
      check("fair first grant m0", 32'(valid_slave), 32'h1);
      tick();
      check("fair bubble", 32'(valid_slave), 32'h0);
      check("fair hs m0", 32'(handshake_slave), 32'h1);
      tick();
      check("fair second grant m1", 32'(valid_slave), 32'h2);
      check("fair m1 value", 32'(value_out), 32'd2);
      tick();
      check("fair hs m1", 32'(handshake_slave), 32'h2);
      tick();
    end

    // Drop: second strobe while pending is ignored
    ready_slave = 2'b00;
    post(2'b01, 7'b0_001_001, '0);
    post(2'b01, 7'b0_111_111, '0);
    check("drop addr", 32'(addr_out), 32'd1);
    check("drop value", 32'(value_out), 32'd1);
    ready_slave = 2'b01;
    tick();
    check("drop hs", 32'(handshake_slave), 32'h1);
    tick(3);
    check("drop nothing more", 32'(valid_slave), 32'h0);
    check("drop in_ready", 32'(in_ready), 32'h3);

    // Reset in the middle of SEND
    ready_slave = 2'b00;
    post(2'b01, 7'b0_101_011, '0);
    tick();
    check("rst pre valid", 32'(valid_slave), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst valid", 32'(valid_slave), 32'h0);
    check("rst addr", 32'(addr_out), 32'h0);
    check("rst value", 32'(value_out), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h3);
    check("rst hs", 32'(handshake_slave), 32'h0);
    ready_slave = 2'b01;
    tick();
    rst_n = 1'b1;
    tick(2);
    check("rst no hs after", 32'(handshake_slave), 32'h0);
    check("rst no valid after", 32'(valid_slave), 32'h0);

`ifdef INTER_TIMEOUT_EN
    ready_slave = 2'b00;
    post(2'b11, 7'b0_000_001, 7'b1_000_010);
    tick();
    check("to first valid", 32'(valid_slave), 32'h1);
    tick(15);
    check("to still waiting", 32'(valid_slave), 32'h1);
    check("to not yet", 32'(timeout_err), 32'h0);
    tick();
    check("to pulse", 32'(timeout_err), 32'h1);
    check("to valid drop", 32'(valid_slave), 32'h0);
    check("to no hs", 32'(handshake_slave), 32'h0);
    tick();
    check("to next grant m1", 32'(valid_slave), 32'h2);
    check("to pulse off", 32'(timeout_err), 32'h0);
    ready_slave = 2'b10;
    tick();
    check("to m1 hs", 32'(handshake_slave), 32'h2);
    tick();
`endif

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      in_valid    = r[1:0];
      data_in     = r[15:2];
      ready_slave = (c % 200 < 40) ? 2'b00 : r[17:16] | {1'b0, r[18]};
      tick();
    end
    in_valid = '0;
    ready_slave = 2'b11;
    tick(10);
    check("final idle in_ready", 32'(in_ready), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
